// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column at a time, synchronised row
// sampling at the end of each dwell, and scan-level debounce into one-cycle key events.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no key accepted, waiting for a scan that decodes to one key
// CONFIRM  | candidate key seen on cnt consecutive scans, not yet accepted
// HELD     | key accepted and still pressed
// REL_WAIT | accepted key absent for cnt consecutive scans, not yet released
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CONFIRM  = 2'd1,
      HELD     = 2'd2,
      REL_WAIT = 2'd3
   } state_t;

   logic [3:0]       row_s1;
   logic [3:0]       row_s2;
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       col_idx;
   logic             dwell_end;
   logic             scan_end;

   logic [1:0]       acc_zeros;
   logic [3:0]       acc_code;
   logic [2:0]       zeros_now;
   logic [3:0]       code_now;
   logic [2:0]       zero_sum;
   logic [1:0]       total_zeros;
   logic             res_valid;
   logic [3:0]       res_code;

   state_t           state;
   state_t           state_nx;
   logic [3:0]       cand;
   logic [3:0]       cand_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] cnt_inc;
   logic [3:0]       code_nx;
   logic             valid_nx;

   function automatic logic [3:0] decode(input logic [1:0] c, input logic [1:0] r);
      logic [3:0] code;
      case ({c, r})
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h4;
         4'd2:    code = 4'h7;
         4'd3:    code = 4'h0;
         4'd4:    code = 4'h2;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h8;
         4'd7:    code = 4'hF;
         4'd8:    code = 4'h3;
         4'd9:    code = 4'h6;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hE;
         4'd12:   code = 4'hA;
         4'd13:   code = 4'hB;
         4'd14:   code = 4'hC;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   assign dwell_end = (div_cnt == DIV_LAST);
   assign scan_end  = dwell_end && (col_idx == 2'd3);
   assign Col       = ~(4'b0001 << col_idx);
   assign key_held  = (state == HELD) || (state == REL_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1  <= 4'hF;
         row_s2  <= 4'hF;
         div_cnt <= '0;
         col_idx <= '0;
      end else begin
         row_s1 <= Row;
         row_s2 <= row_s1;
         if (dwell_end) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
         end else begin
            div_cnt <= div_cnt + DIV_ONE;
         end
      end
   end

   // Scan result folds the current column's sample into the running totals so the
   // FSM can act on the complete scan in the same cycle as the col 3 sample.
   always_comb begin
      zeros_now = '0;
      code_now  = '0;
      for (int r = 3; r >= 0; r--) begin
         if (!row_s2[r]) begin
            zeros_now = zeros_now + 3'd1;
            code_now  = decode(col_idx, 2'(r));
         end
      end
      zero_sum    = {1'b0, acc_zeros} + zeros_now;
      total_zeros = (zero_sum >= 3'd2) ? 2'd2 : zero_sum[1:0];
      res_valid   = (total_zeros == 2'd1);
      res_code    = (acc_zeros == 2'd0) ? code_now : acc_code;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_zeros <= '0;
         acc_code  <= '0;
      end else if (dwell_end) begin
         if (scan_end) begin
            acc_zeros <= '0;
            acc_code  <= '0;
         end else begin
            acc_zeros <= total_zeros;
            acc_code  <= res_code;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cand      <= '0;
         cnt       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         cand      <= cand_nx;
         cnt       <= cnt_nx;
         key_code  <= code_nx;
         key_valid <= valid_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      cnt_nx   = cnt;
      code_nx  = key_code;
      valid_nx = 1'b0;
      cnt_inc  = cnt + CNT_ONE;
      if (scan_end) begin
         case (state)
            IDLE: begin
               if (res_valid) begin
                  state_nx = CONFIRM;
                  cand_nx  = res_code;
                  cnt_nx   = CNT_ONE;
               end
            end
            CONFIRM: begin
               if (!res_valid) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else if (res_code == cand) begin
                  if (cnt_inc == CNT_DONE) begin
                     state_nx = HELD;
                     cnt_nx   = '0;
                     code_nx  = cand;
                     valid_nx = 1'b1;
                  end else begin
                     cnt_nx = cnt_inc;
                  end
               end else begin
                  cand_nx = res_code;
                  cnt_nx  = CNT_ONE;
               end
            end
            HELD: begin
               if (!res_valid) begin
                  state_nx = REL_WAIT;
                  cnt_nx   = CNT_ONE;
               end
            end
            REL_WAIT: begin
               if (res_valid) begin
                  state_nx = HELD;
                  cnt_nx   = '0;
               end else if (cnt_inc == CNT_DONE) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives Row from Col and a set of pressed keys,
// and a scan-level debounce model predicts every output cycle by cycle.
module tb_keypad_scanner;

   localparam int SD   = 4;
   localparam int DB   = 3;
   localparam int SCAN = 4 * SD;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] Row;
   logic [3:0] Col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] pressed = '0;
   bit          chk_en = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   int          cyc = 0;
   logic [3:0]  exp_col = 4'b1110;
   logic [3:0]  exp_code = '0;
   logic        exp_valid = 1'b0;
   logic        exp_held = 1'b0;
   int          streak_len = 0;
   int          none_len = 0;
   logic [3:0]  streak_code = '0;
   int          m_n;
   logic [3:0]  m_res;
   bit          m_hit;

   int          pulse_cnt = 0;
   int          last_pulse_cyc = -1;
   logic [3:0]  last_pulse_code = '0;
   int          held_fall_cyc = -1;
   bit          held_q = 1'b0;

   int          t0;
   int          p0;
   logic [3:0]  col_seq [4];

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .Row       (Row),
      .Col       (Col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] key_at(input int r, input int c);
      logic [3:0] k;
      case (c * 4 + r)
         0: k = 4'h1;  1: k = 4'h4;  2: k = 4'h7;  3: k = 4'h0;
         4: k = 4'h2;  5: k = 4'h5;  6: k = 4'h8;  7: k = 4'hF;
         8: k = 4'h3;  9: k = 4'h6; 10: k = 4'h9; 11: k = 4'hE;
        12: k = 4'hA; 13: k = 4'hB; 14: k = 4'hC; default: k = 4'hD;
      endcase
      return k;
   endfunction

   function automatic logic [15:0] km(input int code);
      logic [15:0] one;
      one = 16'd1;
      return one << code;
   endfunction

   // Physical keypad: a pressed key pulls its row low only while its column is driven.
   always_comb begin
      Row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (Col[c] == 1'b0 && pressed[key_at(r, c)])
               Row[r] = 1'b0;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: a scan yields a key only when exactly one key is down for the whole scan.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         cyc = 0; exp_valid = 1'b0; exp_held = 1'b0; exp_code = '0;
         streak_len = 0; none_len = 0; streak_code = '0;
      end else begin
         exp_valid = 1'b0;
         if (cyc % SCAN == SCAN - 1) begin
            m_n = $countones(pressed);
            m_hit = (m_n == 1);
            m_res = '0;
            for (int k = 0; k < 16; k++) if (pressed[k]) m_res = 4'(k);
            if (!exp_held) begin
               if (m_hit && streak_len > 0 && m_res == streak_code) streak_len++;
               else if (m_hit) begin streak_code = m_res; streak_len = 1; end
               else streak_len = 0;
               if (streak_len == DB) begin
                  exp_valid = 1'b1; exp_code = m_res; exp_held = 1'b1;
                  streak_len = 0; none_len = 0;
               end
            end else begin
               if (m_hit) none_len = 0; else none_len++;
               if (none_len == DB) begin exp_held = 1'b0; none_len = 0; end
            end
         end
         cyc++;
      end
      exp_col = ~(4'b0001 << ((cyc / SD) % 4));
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("col", Col, exp_col);
         check("key_valid", key_valid, exp_valid);
         check("key_held", key_held, exp_held);
         check("key_code", key_code, exp_code);
         if (key_valid === 1'b1) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
            last_pulse_code = key_code;
         end
         if (held_q && key_held === 1'b0) held_fall_cyc = cyc;
         held_q = (key_held === 1'b1);
      end
   end

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic run(input logic [15:0] mask, input int n);
      pressed = mask;
      repeat (SCAN * n) @(negedge clk);
   endtask

   initial begin
      col_seq[0] = 4'b1110; col_seq[1] = 4'b1101;
      col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;

      // reset and column stepping
      @(negedge clk);
      do_reset(2);
      #1;
      check("t1_rst_col", Col, 4'b1110);
      check("t1_rst_valid", key_valid, 1'b0);
      check("t1_rst_held", key_held, 1'b0);
      check("t1_rst_code", key_code, 4'h0);
      for (int i = 1; i < 4; i++) begin
         repeat (SD) @(negedge clk);
         #1;
         check("t1_col_step", Col, col_seq[i]);
      end
      repeat (SD) @(negedge clk);
      #1;
      check("t1_col_wrap", Col, col_seq[0]);

      // clean press of '5' then release
      t0 = cyc; p0 = pulse_cnt; held_fall_cyc = -1;
      run(km(5), 5);
      run('0, 3);
      #1;
      check("t2_pulses", pulse_cnt - p0, 1);
      check("t2_pulse_cyc", last_pulse_cyc - t0, 48);
      check("t2_code", last_pulse_code, 4'h5);
      check("t2_held_fall", held_fall_cyc - t0, 128);

      // bouncing '9'
      t0 = cyc; p0 = pulse_cnt; held_fall_cyc = -1;
      run(km(9), 2);
      run('0, 1);
      run(km(9), 3);
      run('0, 3);
      #1;
      check("t3_pulses", pulse_cnt - p0, 1);
      check("t3_pulse_cyc", last_pulse_cyc - t0, 96);
      check("t3_code", last_pulse_code, 4'h9);
      check("t3_held_fall", held_fall_cyc - t0, 144);

      // two keys at once is ignored
      p0 = pulse_cnt;
      run(km(1) | km(4'hA), 6);
      #1;
      check("t4_pulses", pulse_cnt - p0, 0);
      check("t4_held", key_held, 1'b0);
      check("t4_code_kept", key_code, 4'h9);
      run('0, 1);

      // reset while a candidate is pending, key kept down
      p0 = pulse_cnt;
      run(km(4'hD), 2);
      #1;
      check("t5_no_pulse_pre_rst", pulse_cnt - p0, 0);
      do_reset(2);
      #1;
      t0 = cyc;
      check("t5_rst_cyc", t0, 0);
      check("t5_rst_code", key_code, 4'h0);
      run(km(4'hD), 4);
      run('0, 3);
      #1;
      check("t5_pulses", pulse_cnt - p0, 1);
      check("t5_pulse_cyc", last_pulse_cyc - t0, 48);
      check("t5_code", last_pulse_code, 4'hD);

      // second key while held gives no event until released and pressed alone
      t0 = cyc; p0 = pulse_cnt;
      run(km(0), 4);
      #1;
      check("t6_first_pulses", pulse_cnt - p0, 1);
      check("t6_first_code", key_code, 4'h0);
      run(km(0) | km(4'hF), 2);
      run('0, 3);
      run(km(4'hF), 3);
      run('0, 3);
      #1;
      check("t6_pulses", pulse_cnt - p0, 2);
      check("t6_code", last_pulse_code, 4'hF);
      check("t6_pulse_cyc", last_pulse_cyc - t0, 192);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
